// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//   - NUM_DIGITS_DEFAULT : default number of multiplexed digits
//   - digit code layout  : [3:0] hex value, [4] decimal point, [5] blank
//   - FONT               : active-high segment patterns for 0-F, bits g..a
//   - hex_to_segments()  : hex nibble to active-high segment pattern
package seven_segment_pkg;

    localparam int NUM_DIGITS_DEFAULT = 4;

    localparam int DIGIT_CODE_W = 6;
    localparam int VALUE_LSB    = 0;
    localparam int VALUE_MSB    = 3;
    localparam int DP_BIT       = 4;
    localparam int BLANK_BIT    = 5;

    typedef logic [DIGIT_CODE_W-1:0] digit_code_t;

    // A, C, E, F uppercase; b, d lowercase so they differ from 8 and 0.
    localparam logic [6:0] FONT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_segments(input logic [3:0] i_hex);
        return FONT[i_hex];
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to 7-segment decoder (active-high, bits g..a).
//   i_hex      : 4-bit hex value
//   o_segments : segment pattern, [0]=a .. [6]=g
module hex_to_seven_segment
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_segments
);

    assign o_segments = hex_to_segments(i_hex);

endmodule

// File: rtl/seven_segment_with_dp_driver.sv
// Multiplexed driver for an N-digit 7-segment display with per-digit DP.
// A digit index advances on each next_segment strobe; the selected digit's
// code is decoded and registered together with the one-hot digit select, so
// selector and segments always change on the same edge.
//   clock              : system clock, rising edge
//   resetn             : synchronous active-low reset
//   next_segment       : strobe, advances the digit index once per cycle high
//   digits             : per-digit code, [3:0] value, [4] DP, [5] blank
//   segment_out        : [0]=a .. [6]=g, [7]=dp, polarity per SEGMENT_ACTIVE_HIGH
//   digit_selector_out : one-hot digit enable, polarity per DIGIT_ACTIVE_HIGH
module seven_segment_with_dp_driver
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS          = NUM_DIGITS_DEFAULT,
    parameter bit SEGMENT_ACTIVE_HIGH = 1'b1,
    parameter bit DIGIT_ACTIVE_HIGH   = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  next_segment,
    input  digit_code_t           digits [0:NUM_DIGITS-1],
    output logic [7:0]            segment_out,
    output logic [NUM_DIGITS-1:0] digit_selector_out
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0]      r_index;
    logic [7:0]            r_segment;
    logic [NUM_DIGITS-1:0] r_selector;

    digit_code_t           w_code;
    logic [6:0]            w_font;
    logic [7:0]            w_seg_lit;
    logic [NUM_DIGITS-1:0] w_sel_lit;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_index <= '0;
        end else if (next_segment) begin
            r_index <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
        end
    end

    assign w_code = digits[r_index];

    hex_to_seven_segment u_decoder (
        .i_hex      (w_code[VALUE_MSB:VALUE_LSB]),
        .o_segments (w_font)
    );

    // Blank suppresses DP as well; the digit stays selected so the scan
    // duty cycle is unchanged.
    assign w_seg_lit = w_code[BLANK_BIT] ? 8'h00 : {w_code[DP_BIT], w_font};

    always_comb begin
        w_sel_lit          = '0;
        w_sel_lit[r_index] = 1'b1;
    end

    // Polarity is applied here so the pins never glitch through a
    // combinational inverter.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_segment  <= {8{~SEGMENT_ACTIVE_HIGH}};
            r_selector <= {NUM_DIGITS{~DIGIT_ACTIVE_HIGH}};
        end else begin
            r_segment  <= SEGMENT_ACTIVE_HIGH ? w_seg_lit : ~w_seg_lit;
            r_selector <= DIGIT_ACTIVE_HIGH ? w_sel_lit : ~w_sel_lit;
        end
    end

    assign segment_out        = r_segment;
    assign digit_selector_out = r_selector;

endmodule

// File: tb/tb_seven_segment_with_dp_driver.sv
module tb_seven_segment_with_dp_driver;

    logic       clock;
    logic       resetn;
    logic       next_segment;
    logic [5:0] digits   [0:3];
    logic [5:0] digits_p [0:3];
    logic [7:0] segment_out;
    logic [3:0] digit_selector_out;
    logic [7:0] segment_out_p;
    logic [3:0] digit_selector_out_p;

    int errors = 0;
    int checks = 0;

    seven_segment_with_dp_driver #(
        .NUM_DIGITS          (4),
        .SEGMENT_ACTIVE_HIGH (1'b1),
        .DIGIT_ACTIVE_HIGH   (1'b1)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .next_segment       (next_segment),
        .digits             (digits),
        .segment_out        (segment_out),
        .digit_selector_out (digit_selector_out)
    );

    seven_segment_with_dp_driver #(
        .NUM_DIGITS          (4),
        .SEGMENT_ACTIVE_HIGH (1'b0),
        .DIGIT_ACTIVE_HIGH   (1'b0)
    ) dut_inv (
        .clock              (clock),
        .resetn             (resetn),
        .next_segment       (next_segment),
        .digits             (digits_p),
        .segment_out        (segment_out_p),
        .digit_selector_out (digit_selector_out_p)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        next_segment = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(2);
    endtask

    task automatic strobe_once();
        next_segment = 1'b1;
        cyc(1);
        next_segment = 1'b0;
        cyc(9);
    endtask

    task automatic set_digits_1234();
        digits[0] = 6'h01;
        digits[1] = 6'h02;
        digits[2] = 6'h03;
        digits[3] = 6'h04;
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        next_segment = 1'b0;
        for (int i = 0; i < 4; i++) begin
            digits[i]   = 6'h00;
            digits_p[i] = 6'h00;
        end
        cyc(3);
        checks++;
        if (segment_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_seg: got %h expected 00", segment_out);
        end
        checks++;
        if (digit_selector_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sel: got %b expected 0000", digit_selector_out);
        end
        checks++;
        if (segment_out_p !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg_inv: got %h expected FF", segment_out_p);
        end
        checks++;
        if (digit_selector_out_p !== 4'b1111) begin
            errors++;
            $display("FAIL reset_sel_inv: got %b expected 1111", digit_selector_out_p);
        end
        resetn = 1'b1;
        cyc(2);
        checks++;
        if (digit_selector_out !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_sel: got %b expected 0001", digit_selector_out);
        end
        checks++;
        if (segment_out !== 8'h3F) begin
            errors++;
            $display("FAIL post_reset_seg: got %h expected 3F", segment_out);
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] exp_sel [0:4];
        logic [7:0] exp_seg [0:4];
        exp_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_seg = '{8'h5B, 8'h4F, 8'h66, 8'h06, 8'h5B};
        do_reset();
        set_digits_1234();
        cyc(2);
        checks++;
        if (digit_selector_out !== 4'b0001 || segment_out !== 8'h06) begin
            errors++;
            $display("FAIL scan_start: got sel=%b seg=%h expected sel=0001 seg=06",
                     digit_selector_out, segment_out);
        end
        for (int s = 0; s < 5; s++) begin
            strobe_once();
            checks++;
            if (digit_selector_out !== exp_sel[s]) begin
                errors++;
                $display("FAIL scan_sel[%0d]: got %b expected %b", s, digit_selector_out, exp_sel[s]);
            end
            checks++;
            if (segment_out !== exp_seg[s]) begin
                errors++;
                $display("FAIL scan_seg[%0d]: got %h expected %h", s, segment_out, exp_seg[s]);
            end
        end
    endtask

    // Index is 1 on entry: strobe sampled at edge k, index changes after k,
    // outputs show the new digit only after edge k+1.
    task automatic test_strobe_latency();
        next_segment = 1'b1;
        cyc(1);
        next_segment = 1'b0;
        checks++;
        if (digit_selector_out !== 4'b0010 || segment_out !== 8'h5B) begin
            errors++;
            $display("FAIL strobe_latency_old: got sel=%b seg=%h expected sel=0010 seg=5B",
                     digit_selector_out, segment_out);
        end
        cyc(1);
        checks++;
        if (digit_selector_out !== 4'b0100 || segment_out !== 8'h4F) begin
            errors++;
            $display("FAIL strobe_latency_new: got sel=%b seg=%h expected sel=0100 seg=4F",
                     digit_selector_out, segment_out);
        end
    endtask

    task automatic test_dp_blank();
        do_reset();
        digits[0] = 6'h08;
        cyc(1);
        checks++;
        if (segment_out !== 8'h7F) begin
            errors++;
            $display("FAIL digit_8: got %h expected 7F", segment_out);
        end
        digits[0] = 6'h18;
        cyc(1);
        checks++;
        if (segment_out !== 8'hFF) begin
            errors++;
            $display("FAIL dp_on: got %h expected FF", segment_out);
        end
        digits[0] = 6'h38;
        cyc(1);
        checks++;
        if (segment_out !== 8'h00) begin
            errors++;
            $display("FAIL blank_seg: got %h expected 00", segment_out);
        end
        checks++;
        if (digit_selector_out !== 4'b0001) begin
            errors++;
            $display("FAIL blank_sel: got %b expected 0001", digit_selector_out);
        end
    endtask

    task automatic test_font_sweep();
        logic [7:0] font_exp [0:15];
        font_exp = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                     8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        for (int v = 0; v < 16; v++) begin
            digits[0] = 6'(v);
            cyc(1);
            checks++;
            if (segment_out !== font_exp[v]) begin
                errors++;
                $display("FAIL font[%0h]: got %h expected %h", v, segment_out, font_exp[v]);
            end
        end
    endtask

    task automatic test_polarity();
        do_reset();
        digits_p[0] = 6'h08;
        cyc(2);
        checks++;
        if (segment_out_p !== 8'h80) begin
            errors++;
            $display("FAIL polarity_seg: got %h expected 80", segment_out_p);
        end
        checks++;
        if (digit_selector_out_p !== 4'b1110) begin
            errors++;
            $display("FAIL polarity_sel: got %b expected 1110", digit_selector_out_p);
        end
        digits_p[0] = 6'h38;
        cyc(1);
        checks++;
        if (segment_out_p !== 8'hFF || digit_selector_out_p !== 4'b1110) begin
            errors++;
            $display("FAIL polarity_blank: got seg=%h sel=%b expected seg=FF sel=1110",
                     segment_out_p, digit_selector_out_p);
        end
    endtask

    task automatic test_back_to_back();
        set_digits_1234();
        do_reset();
        next_segment = 1'b1;
        cyc(3);
        next_segment = 1'b0;
        cyc(2);
        checks++;
        if (digit_selector_out !== 4'b1000) begin
            errors++;
            $display("FAIL held_strobe_sel: got %b expected 1000", digit_selector_out);
        end
        checks++;
        if (segment_out !== 8'h66) begin
            errors++;
            $display("FAIL held_strobe_seg: got %h expected 66", segment_out);
        end
        next_segment = 1'b1;
        cyc(2);
        next_segment = 1'b0;
        cyc(2);
        checks++;
        if (digit_selector_out !== 4'b0010) begin
            errors++;
            $display("FAIL held_strobe_wrap: got %b expected 0010", digit_selector_out);
        end
    endtask

    task automatic test_strobe_with_reset();
        set_digits_1234();
        do_reset();
        strobe_once();
        strobe_once();
        checks++;
        if (digit_selector_out !== 4'b0100) begin
            errors++;
            $display("FAIL pre_reset_sel: got %b expected 0100", digit_selector_out);
        end
        resetn       = 1'b0;
        next_segment = 1'b1;
        cyc(1);
        checks++;
        if (digit_selector_out !== 4'b0000 || segment_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobe_outputs: got sel=%b seg=%h expected sel=0000 seg=00",
                     digit_selector_out, segment_out);
        end
        resetn       = 1'b1;
        next_segment = 1'b0;
        cyc(2);
        checks++;
        if (digit_selector_out !== 4'b0001 || segment_out !== 8'h06) begin
            errors++;
            $display("FAIL reset_strobe_index: got sel=%b seg=%h expected sel=0001 seg=06",
                     digit_selector_out, segment_out);
        end
    endtask

    initial begin
        test_reset();
        test_scan_wrap();
        test_strobe_latency();
        test_dp_blank();
        test_font_sweep();
        test_polarity();
        test_back_to_back();
        test_strobe_with_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_with_dp_driver.md
Name: seven_segment_with_dp_driver

Overview:
- Multiplexed driver for a 4-digit, 7-segment display with a decimal point (DP) per digit.
- Holds one digit index that advances on a one-cycle `next_segment` strobe. The strobe comes from an external ~1 kHz refresh timer.
- Decodes the selected digit's 6-bit code into segment lines a–g plus DP, and drives exactly one digit-select line at a time.
- Sits between the CPU-writable digit registers and the board's segment/digit pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; the index wraps at NUM_DIGITS-1.
- SEGMENT_ACTIVE_HIGH, 1, 1: a lit segment/DP drives 1; 0: inverted.
- DIGIT_ACTIVE_HIGH, 1, 1: the selected digit line drives 1; 0: inverted.

Ports:
- clock, input, 1, single system clock; all logic on its rising edge.
- resetn, input, 1, synchronous active-low reset.
- next_segment, input, 1, one-cycle strobe that advances to the next digit.
- digits, input, 6 x NUM_DIGITS (unpacked array [0:NUM_DIGITS-1] of 6 bits), per-digit code: [3:0] hex value, [4] DP on, [5] blank.
- segment_out, output, 8, [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp.
- digit_selector_out, output, NUM_DIGITS, one-hot digit enable; bit i drives digit i.

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-low, `resetn`.
- Reset (resetn=0 at a rising edge):
  - index <= 0.
  - segment_out <= all inactive level.
  - digit_selector_out <= all inactive level.
- Index advance: on each clock with resetn=1 and next_segment=1, index <= (index==NUM_DIGITS-1) ? 0 : index+1.
  - next_segment held high for N cycles advances the index N times.
  - next_segment asserted in the same cycle as reset is ignored; reset wins.
- Outputs are registered and track the current index and the current `digits` content with 1-cycle latency:
  - digit_selector_out: only bit[index] active.
  - segment_out[6:0]: font(digits[index][3:0]).
  - segment_out[7]: digits[index][4].
  - Blank (digits[index][5]=1): segment_out[7:0] all inactive; digit_selector_out still one-hot.
  - `digits` may change at any time. The new value appears on the outputs the cycle after it is sampled; no re-sync to next_segment.
- Strobe timing: the cycle after the edge that samples next_segment=1, index has changed. One cycle after that, outputs show the new digit, so selector and segments always switch together.
- Polarity: the inactive level is 0 when the matching *_ACTIVE_HIGH=1, else 1. Polarity is applied at the output register.
- Font (active-high, bits g..a), 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. A, C, E, F are uppercase; b, d are lowercase.
- No dead-time insertion; one-hot selection holds in every cycle after the first post-reset cycle.

Decomposition:
- Package seven_segment_pkg:
  - NUM_DIGITS default constant.
  - Digit-code field positions: VALUE [3:0], DP bit 4, BLANK bit 5.
  - 16-entry font constant array.
  - Function hex_to_segments(logic [3:0]) -> logic [6:0].
- Optional sub-module hex_to_seven_segment: combinational 4-bit hex to 7-bit segment decoder, instantiated once on the selected digit.

Test Plan:
- Reset: resetn=0 for 3 cycles, then 1 with digits all 6'h00 and no strobe → selector 4'b0001, segment_out 8'h3F from the second cycle after release.
- Scan and wrap:
  - digits = {6'h01, 6'h02, 6'h03, 6'h04} (digits[0]..digits[3]).
  - 5 single strobes, each 10 cycles apart.
  - Selector sequence: 0001 → 0010 → 0100 → 1000 → 0001 → 0010.
  - Segments per step: 06, 5B, 4F, 66, 06, 5B.
- DP and blank:
  - digits[0]=6'h18 → segment_out 8'hFF.
  - digits[0]=6'h38 → segment_out 8'h00, selector stays 0001.
- Full font sweep: digits[0] = 0..F, one value per cycle → segment_out follows the font table with 1-cycle latency.
- Polarity: SEGMENT_ACTIVE_HIGH=0, DIGIT_ACTIVE_HIGH=0, digits[0]=6'h08 → segment_out 8'h80, selector 4'b1110. In reset: segment_out 8'hFF, selector 4'b1111.
- Corner cases:
  - next_segment held high 3 cycles from index 0 → index 3, selector 4'b1000.
  - Strobe together with resetn=0 → index 0.
